// File: rtl/helloworld_response_monitor.sv
// helloworld_response_monitor: MISR signature, toggle count and pass/fail verdict over a capture window.
//   bertaClock   - sole clock, rising edge
//   global_reset - asynchronous active-low reset
//   start        - begin a capture window (from IDLE or DONE)
//   abort        - cancel the window; wins over start
//   resp_valid   - resp_in is sampled this cycle
//   resp_in      - packed netlist outputs {u38..u34, z5..z0}
//   expected_sig - golden signature, sampled when the window closes
//   busy/done    - CAPTURE / DONE state flags
//   pass         - verdict, meaningful while done=1
//   signature    - current MISR contents
//   toggle_count - saturating count of output bit toggles
//   sample_count - valid samples taken in the current window
module helloworld_response_monitor #(
  parameter int              OUT_W  = 11,
  parameter int              SIG_W  = 16,
  parameter logic [SIG_W-1:0] POLY  = 16'h1021,
  parameter logic [SIG_W-1:0] SEED  = 16'h0000,
  parameter int              CYCLES = 64,
  parameter int              CNT_W  = 16
) (
  input  logic             bertaClock,
  input  logic             global_reset,
  input  logic             start,
  input  logic             abort,
  input  logic             resp_valid,
  input  logic [OUT_W-1:0] resp_in,
  input  logic [SIG_W-1:0] expected_sig,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] signature,
  output logic [CNT_W-1:0] toggle_count,
  output logic [CNT_W-1:0] sample_count
);
  localparam int POP_W = $clog2(OUT_W + 1);
  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DONE} state_t;
  state_t           r_state, w_next;
  logic [SIG_W-1:0] r_sig, w_misr;
  logic [CNT_W-1:0] r_tog, r_cnt, w_tog;
  logic [CNT_W:0]   w_tog_sum;
  logic [OUT_W-1:0] r_prev;
  logic [POP_W-1:0] w_pop;
  logic             r_pass, w_arm, w_step, w_close;
  // abort blocks both re-arming and sampling, so a cancelled window keeps its debug values
  always_comb begin
    w_arm   = start && !abort && r_state != S_CAPTURE;
    w_step  = resp_valid && !abort && r_state == S_CAPTURE;
    w_close = w_step && r_cnt == CNT_W'(CYCLES - 1);
    w_next  = abort ? S_IDLE : w_arm ? S_CAPTURE : w_close ? S_DONE : r_state;
  end
  always_comb begin
    w_pop = '0;
    for (int i = 0; i < OUT_W; i++) w_pop = w_pop + POP_W'(resp_in[i] ^ r_prev[i]);
    w_misr    = {r_sig[SIG_W-2:0], 1'b0} ^ (r_sig[SIG_W-1] ? POLY : '0) ^ SIG_W'(resp_in);
    w_tog_sum = {1'b0, r_tog} + (CNT_W + 1)'(w_pop);
    w_tog     = w_tog_sum[CNT_W] ? '1 : w_tog_sum[CNT_W-1:0];
  end
  always_ff @(posedge bertaClock or negedge global_reset)
    if (!global_reset) r_state <= S_IDLE;
    else r_state <= w_next;
  always_ff @(posedge bertaClock or negedge global_reset) begin
    if (!global_reset) begin
      r_sig  <= SEED;
      r_tog  <= '0;
      r_cnt  <= '0;
      r_prev <= '0;
      r_pass <= 1'b0;
    end else begin
      if (w_arm) begin
        r_sig  <= SEED;
        r_tog  <= '0;
        r_cnt  <= '0;
        r_prev <= '0;
        r_pass <= 1'b0;
      end else if (w_step) begin
        r_sig  <= w_misr;
        r_tog  <= w_tog;
        r_cnt  <= r_cnt + CNT_W'(1);
        r_prev <= resp_in;
        if (w_close) r_pass <= w_misr == expected_sig;
      end
      if (abort) r_pass <= 1'b0;
    end
  end
  assign busy         = r_state == S_CAPTURE;
  assign done         = r_state == S_DONE;
  assign pass         = r_pass;
  assign signature    = r_sig;
  assign toggle_count = r_tog;
  assign sample_count = r_cnt;
endmodule

// File: doc/helloworld_response_monitor.md
Name: helloworld_response_monitor

Overview:
- Downstream consumer of the HelloWorld netlist outputs (z0..z5, u34..u38 packed into one 11-bit response bus).
- Over a programmed window it compresses the response stream into a MISR signature, counts output bit toggles and compares the signature with an expected value.
- Produces a registered pass/fail verdict, usable by the test bench or on-chip self-test.

Parameters:
- OUT_W, 11, response bus width (bit 0 = z0 … bit 5 = z5, bit 6 = u34 … bit 10 = u38).
- SIG_W, 16, MISR/signature width; must be ≥ OUT_W.
- POLY, 16'h1021, MISR feedback polynomial (CRC-CCITT taps).
- SEED, 16'h0000, signature value loaded on start.
- CYCLES, 64, number of valid samples per capture window; must be ≥ 1.
- CNT_W, 16, width of toggle_count and sample_count.

Ports:
- bertaClock  input  1  sole clock; all state updates on its rising edge.
- global_reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to begin a capture window.
- abort  input  1  cancels a window and returns to IDLE.
- resp_valid  input  1  resp_in is sampled this cycle.
- resp_in  input  OUT_W  packed netlist outputs.
- expected_sig  input  SIG_W  golden signature; sampled when the window closes.
- busy  output  1  high in CAPTURE.
- done  output  1  high in DONE.
- pass  output  1  verdict; meaningful only while done=1.
- signature  output  SIG_W  current MISR contents.
- toggle_count  output  CNT_W  accumulated bit toggles, saturating.
- sample_count  output  CNT_W  valid samples taken in the current window.

Behaviour:
- Reset (global_reset=0, asynchronous): state=IDLE; busy=0, done=0, pass=0; signature=SEED; toggle_count=0; sample_count=0; prev_resp=0.
- FSM states: IDLE, CAPTURE, DONE.
- IDLE:
  - start=1 → CAPTURE next cycle.
  - On that same edge: signature←SEED, toggle_count←0, sample_count←0, prev_resp←0.
- CAPTURE, on each cycle with resp_valid=1:
  - MISR step: f=signature[SIG_W-1]; next = ((signature<<1) ^ (f ? POLY : 0)) ^ zero-extend(resp_in).
  - toggle_count += popcount(resp_in ^ prev_resp), saturating at all-ones.
  - prev_resp ← resp_in.
  - sample_count += 1.
- resp_valid=0: all registers hold.
- Window close: on the edge where sample_count becomes CYCLES, state→DONE and pass←(next signature == expected_sig). done rises the cycle after the last valid sample (latency 1).
- DONE:
  - Outputs and counters hold.
  - start=1 re-arms exactly as from IDLE and goes to CAPTURE.
  - resp_valid is ignored.
- start while in CAPTURE is ignored.
- abort=1 in CAPTURE or DONE → IDLE next cycle; pass←0; signature and counters hold their values for debug.
- abort and start asserted in the same cycle: abort wins; start is dropped.
- Asynchronous reset mid-window returns to the reset values immediately, without waiting for a clock edge.
- Arithmetic: popcount result is 4 bits for OUT_W=11; the saturating add never wraps.

Test Plan:
- Reset: hold global_reset=0 with activity on all inputs → busy=0, done=0, pass=0, signature=0x0000, counts=0; release reset → remains in IDLE.
- CYCLES=2, SEED=0: start, then resp_in=0x001 valid twice → signature 0x0001 then 0x0003; done=1 one cycle after the 2nd sample; with expected_sig=0x0003 → pass=1; with 0x0004 → pass=0.
- Feedback path: SEED=0x8000, CYCLES=1, resp_in=0x000 → signature=0x1021.
- Toggle and gaps: CYCLES=3; resp_in 0x7FF, idle cycle (resp_valid=0), 0x000, 0x7FF → toggle_count=33, sample_count=3; the idle cycle changes nothing.
- Controls: start mid-CAPTURE → ignored, sample_count continues; abort+start together → IDLE, pass=0; start from DONE → new window starting from SEED.
- Reset mid-window: assert global_reset after 5 of 64 samples → all outputs at reset values asynchronously; a new start captures a clean window.
